// File: rtl/fully_connected_seq.sv
// rtl/fully_connected_seq.sv - fixed-point fully-connected layer with streamed weights and saturating accumulation
module fully_connected_seq #(
  parameter int ADDR_WIDTH = 16,
  parameter int BASE_ADDR  = 0,
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_WIDTH = 16,
  parameter int N_NEURONS  = 10,
  parameter int N_INPUTS   = 64,
  parameter int RELU_EN    = 0
) (
  input  logic                            clock_i,
  input  logic                            reset_ni,
  input  logic                            start_i,
  input  logic                            data_valid_i,
  output logic                            data_ready_o,
  input  logic [DATA_WIDTH-1:0]           data_i,
  input  logic [DATA_WIDTH*N_NEURONS-1:0] biases_i,
  output logic [ADDR_WIDTH-1:0]           ram_rdaddress_o,
  input  logic [DATA_WIDTH-1:0]           ram_weight_i,
  output logic [DATA_WIDTH*N_NEURONS-1:0] logits_o,
  output logic                            done_o,
  output logic                            overflow_o
);

  localparam int W   = DATA_WIDTH;
  localparam int LCW = $clog2(N_NEURONS + 1);
  localparam int ICW = $clog2(N_INPUTS + 1);

  localparam logic [ADDR_WIDTH-1:0] ADDR_BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [LCW-1:0]        LOAD_LAST = LCW'(N_NEURONS);
  localparam logic [LCW-1:0]        LOAD_ONE  = LCW'(1);
  localparam logic [ICW-1:0]        IN_LAST   = ICW'(N_INPUTS - 1);
  localparam logic [ICW-1:0]        IN_ONE    = ICW'(1);

  localparam logic signed [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_READY,
    S_DONE
  } state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  // Position inside a LOAD visit: issue slot while < N_NEURONS, capture slot
  // (weight index load_cnt_q-1) while >= 1.
  logic [LCW-1:0]          load_cnt_q;
  logic [ICW-1:0]          in_cnt_q;
  logic                    ready_q;
  logic                    done_q;
  logic                    ovf_q;
  logic signed [W-1:0]     acc_q    [N_NEURONS];
  logic signed [W-1:0]     weight_q [N_NEURONS];

  logic [W*N_NEURONS-1:0]  acc_d;
  logic [N_NEURONS-1:0]    clamp_d;

  for (genvar n = 0; n < N_NEURONS; n++) begin : g_mac
    logic signed [2*W-1:0] prod;
    logic signed [2*W-1:0] prod_sh;
    logic signed [W-1:0]   prod_sat;
    logic signed [W:0]     sum;
    logic                  prod_clamp;
    logic                  sum_clamp;

    // Full-width product rescaled by the fraction bits, clamped, then added with a clamp.
    always_comb begin
      prod       = {{W{data_i[W-1]}}, data_i} * {{W{weight_q[n][W-1]}}, weight_q[n]};
      prod_sh    = prod >>> FRAC_WIDTH;
      prod_clamp = (prod_sh[2*W-1:W-1] != {(W+1){prod_sh[2*W-1]}});
      prod_sat   = prod_clamp ? (prod_sh[2*W-1] ? SAT_MIN : SAT_MAX) : prod_sh[W-1:0];
      sum        = {prod_sat[W-1], prod_sat} + {acc_q[n][W-1], acc_q[n]};
      sum_clamp  = (sum[W] != sum[W-1]);
    end

    assign acc_d[n*W +: W] = sum_clamp ? (sum[W] ? SAT_MIN : SAT_MAX) : sum[W-1:0];
    assign clamp_d[n]      = prod_clamp | sum_clamp;

    // ReLU is applied on the way out only; the accumulator keeps negative values.
    assign logits_o[n*W +: W] = ((RELU_EN != 0) && acc_q[n][W-1]) ? '0 : acc_q[n];
  end

  // Control FSM with all state, counters, weights and accumulators.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= S_IDLE;
      addr_q     <= ADDR_BASE;
      load_cnt_q <= '0;
      in_cnt_q   <= '0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      for (int n = 0; n < N_NEURONS; n++) begin
        acc_q[n]    <= '0;
        weight_q[n] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_q    <= S_LOAD;
            addr_q     <= ADDR_BASE;
            load_cnt_q <= '0;
            in_cnt_q   <= '0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            for (int n = 0; n < N_NEURONS; n++) begin
              acc_q[n] <= biases_i[n*W +: W];
            end
          end
        end
        S_LOAD: begin
          // Address advances only on issue slots; it carries over into the next input.
          if (load_cnt_q != LOAD_LAST) begin
            addr_q <= addr_q + ADDR_ONE;
          end
          // RAM data lags its address by one cycle, so slot k+1 captures weight k.
          for (int n = 0; n < N_NEURONS; n++) begin
            if (load_cnt_q == LCW'(n + 1)) begin
              weight_q[n] <= ram_weight_i;
            end
          end
          if (load_cnt_q == LOAD_LAST) begin
            state_q    <= S_READY;
            ready_q    <= 1'b1;
            load_cnt_q <= '0;
          end else begin
            load_cnt_q <= load_cnt_q + LOAD_ONE;
          end
        end
        S_READY: begin
          // ready_q is always high here, so valid alone completes the handshake.
          if (data_valid_i) begin
            ready_q  <= 1'b0;
            in_cnt_q <= in_cnt_q + IN_ONE;
            for (int n = 0; n < N_NEURONS; n++) begin
              acc_q[n] <= acc_d[n*W +: W];
            end
            if (|clamp_d) begin
              ovf_q <= 1'b1;
            end
            if (in_cnt_q == IN_LAST) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_LOAD;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign data_ready_o    = ready_q;
  assign done_o          = done_q;
  assign overflow_o      = ovf_q;
  assign ram_rdaddress_o = addr_q;

endmodule

// File: tb/tb_fully_connected_seq.sv
// tb/tb_fully_connected_seq.sv - randomized self-checking bench for fully_connected_seq
module tb_fully_connected_seq;

  localparam int W    = 16;
  localparam int F    = 8;
  localparam int N    = 3;
  localparam int NI   = 2;
  localparam int AW   = 8;
  localparam int BASE = 5;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           valid = 1'b0;
  logic [W-1:0]   data = '0;
  logic [W*N-1:0] biases = '0;
  logic           ready0, ready1, done0, done1, ovf0, ovf1;
  logic [AW-1:0]  addr0, addr1;
  logic [W-1:0]   ram_q0 = '0;
  logic [W-1:0]   ram_q1 = '0;
  logic [W*N-1:0] logits0, logits1;
  logic [W-1:0]   mem [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;

  logic signed [W-1:0] bias_v [N];
  logic signed [W-1:0] data_v [NI];
  longint              exp_acc [N];
  bit                  exp_ovf;
  logic [W-1:0]        basic_exp [N] = '{16'h0500, 16'h0600, 16'h0000};

  int            obs_first_ready, obs_done_cyc, obs_gap_drop, obs_ready_stuck;
  bit            obs_timeout, obs_done_early;
  logic          obs_done, obs_ovf, obs_ps_ovf, obs_ps_done, obs_ps_ready;
  logic [AW-1:0] obs_addr, obs_ps_addr;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ram_q0 <= mem[addr0];
    ram_q1 <= mem[addr1];
  end

  fully_connected_seq #(
    .ADDR_WIDTH(AW), .BASE_ADDR(BASE), .DATA_WIDTH(W), .FRAC_WIDTH(F),
    .N_NEURONS(N), .N_INPUTS(NI), .RELU_EN(0)
  ) dut0 (
    .clock_i(clk), .reset_ni(rst_n), .start_i(start), .data_valid_i(valid),
    .data_ready_o(ready0), .data_i(data), .biases_i(biases),
    .ram_rdaddress_o(addr0), .ram_weight_i(ram_q0), .logits_o(logits0),
    .done_o(done0), .overflow_o(ovf0)
  );

  fully_connected_seq #(
    .ADDR_WIDTH(AW), .BASE_ADDR(BASE), .DATA_WIDTH(W), .FRAC_WIDTH(F),
    .N_NEURONS(N), .N_INPUTS(NI), .RELU_EN(1)
  ) dut1 (
    .clock_i(clk), .reset_ni(rst_n), .start_i(start), .data_valid_i(valid),
    .data_ready_o(ready1), .data_i(data), .biases_i(biases),
    .ram_rdaddress_o(addr1), .ram_weight_i(ram_q1), .logits_o(logits1),
    .done_o(done1), .overflow_o(ovf1)
  );

  // Reference: for each activation in order, every neuron adds the clamped,
  // floor-rescaled product to its clamped running sum.
  task automatic model;
    longint p;
    longint s;
    exp_ovf = 1'b0;
    for (int n = 0; n < N; n++) exp_acc[n] = longint'(bias_v[n]);
    for (int i = 0; i < NI; i++) begin
      for (int n = 0; n < N; n++) begin
        p = (longint'(data_v[i]) * longint'($signed(mem[BASE + i*N + n]))) >>> F;
        if (p > 32767) begin p = 32767; exp_ovf = 1'b1; end
        else if (p < -32768) begin p = -32768; exp_ovf = 1'b1; end
        s = exp_acc[n] + p;
        if (s > 32767) begin s = 32767; exp_ovf = 1'b1; end
        else if (s < -32768) begin s = -32768; exp_ovf = 1'b1; end
        exp_acc[n] = s;
      end
    end
  endtask

  function automatic longint relu(input longint x);
    return (x < 0) ? 64'sd0 : x;
  endfunction

  function automatic logic [15:0] rnd16();
    logic [15:0] r;
    r = 16'($urandom);
    if ($urandom_range(0, 1) == 1) r = {{6{r[9]}}, r[9:0]};
    return r;
  endfunction

  task automatic load_basic;
    bias_v = '{16'sh0100, 16'sh0000, -16'sh0100};
    data_v = '{16'sh0200, 16'sh0400};
    mem[BASE+0] = 16'h0100; mem[BASE+1] = 16'h0200; mem[BASE+2] = 16'hFF80;
    mem[BASE+3] = 16'h0080; mem[BASE+4] = 16'h0080; mem[BASE+5] = 16'h0080;
  endtask

  // Drives one image (start pulse, NI handshakes) and records what it observed.
  task automatic run_image(input int gap, input bit poke_start);
    int elapsed;
    int waited;
    obs_timeout = 0; obs_gap_drop = 0; obs_ready_stuck = 0;
    obs_first_ready = -1; obs_done_early = 0;
    @(negedge clk);
    for (int n = 0; n < N; n++) biases[n*W +: W] = bias_v[n];
    start = 1'b1; valid = 1'b0;
    @(negedge clk);
    start = 1'b0; biases = '1;
    elapsed = 1;
    obs_ps_ovf = ovf0; obs_ps_done = done0; obs_ps_addr = addr0; obs_ps_ready = ready0;
    for (int i = 0; i < NI; i++) begin
      data = data_v[i];
      valid = (gap == 0);
      waited = 0;
      while (ready0 !== 1'b1) begin
        @(negedge clk); elapsed++; waited++;
        if (waited > 200) begin obs_timeout = 1; valid = 1'b0; return; end
      end
      if (i == 0) obs_first_ready = elapsed;
      for (int g = 0; g < gap; g++) begin
        if (ready0 !== 1'b1) obs_gap_drop++;
        @(negedge clk); elapsed++;
      end
      if (ready0 !== 1'b1) obs_gap_drop++;
      if (i == NI-1 && done0 !== 1'b0) obs_done_early = 1;
      if (poke_start && i == NI-1) start = 1'b1;
      valid = 1'b1;
      @(negedge clk); elapsed++;
      valid = 1'b0; start = 1'b0; data = 16'($urandom);
      if (ready0 !== 1'b0) obs_ready_stuck++;
    end
    obs_done_cyc = elapsed; obs_done = done0; obs_ovf = ovf0; obs_addr = addr0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (logits0 !== '0) begin errors++; $display("FAIL reset_logits0: got %h expected 0", logits0); end
    checks++; if (logits1 !== '0) begin errors++; $display("FAIL reset_logits1: got %h expected 0", logits1); end
    checks++; if (addr0 !== AW'(BASE)) begin errors++; $display("FAIL reset_addr: got %0d expected %0d", addr0, BASE); end
    checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready0); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done0); end
    checks++; if (ovf0 !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf0); end
    rst_n = 1'b1;
    valid = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (ready0 !== 1'b0 || logits0 !== '0) begin errors++; $display("FAIL idle_valid: ready %b logits %h expected 0 and 0", ready0, logits0); end
    valid = 1'b0;
  endtask

  task automatic test_basic;
    load_basic();
    model();
    run_image(0, 1'b0);
    checks++; if (obs_timeout) begin errors++; $display("FAIL basic_timeout: no handshake within budget"); return; end
    checks++; if (obs_first_ready != N+2) begin errors++; $display("FAIL basic_first_ready: got cycle %0d expected %0d", obs_first_ready, N+2); end
    checks++; if (obs_done !== 1'b1 || obs_done_cyc != NI*(N+2)+1) begin errors++; $display("FAIL basic_done: done %b at cycle %0d expected 1 at %0d", obs_done, obs_done_cyc, NI*(N+2)+1); end
    checks++; if (obs_done_early) begin errors++; $display("FAIL basic_done_early: done high before final handshake, expected 0"); end
    checks++; if (obs_ready_stuck != 0) begin errors++; $display("FAIL basic_ready_drop: ready high after handshake %0d times, expected 0", obs_ready_stuck); end
    checks++; if (obs_ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b expected 0", obs_ovf); end
    checks++; if (obs_addr !== AW'(BASE + NI*N)) begin errors++; $display("FAIL basic_final_addr: got %0d expected %0d", obs_addr, BASE + NI*N); end
    for (int n = 0; n < N; n++) begin
      checks++; if (logits0[n*W +: W] !== basic_exp[n]) begin errors++; $display("FAIL basic_logit%0d: got %h expected %h", n, logits0[n*W +: W], basic_exp[n]); end
      checks++; if (logits0[n*W +: W] !== 16'(exp_acc[n])) begin errors++; $display("FAIL basic_model%0d: got %h expected %h", n, logits0[n*W +: W], 16'(exp_acc[n])); end
    end
  endtask

  task automatic test_backpressure;
    load_basic();
    run_image(5, 1'b0);
    checks++; if (obs_timeout) begin errors++; $display("FAIL bp_timeout: no handshake within budget"); return; end
    checks++; if (obs_gap_drop != 0) begin errors++; $display("FAIL bp_ready_hold: ready dropped %0d times while waiting, expected 0", obs_gap_drop); end
    checks++; if (obs_done !== 1'b1 || obs_done_cyc != NI*(N+2)+1+10) begin errors++; $display("FAIL bp_done: done %b at cycle %0d expected 1 at %0d", obs_done, obs_done_cyc, NI*(N+2)+11); end
    for (int n = 0; n < N; n++) begin
      checks++; if (logits0[n*W +: W] !== basic_exp[n]) begin errors++; $display("FAIL bp_logit%0d: got %h expected %h", n, logits0[n*W +: W], basic_exp[n]); end
    end
  endtask

  task automatic test_saturation;
    bias_v = '{16'sh7F00, 16'sh0000, 16'sh0000};
    data_v = '{16'sh0200, 16'sh0100};
    mem[BASE+0] = 16'h0100; mem[BASE+1] = 16'h0000; mem[BASE+2] = 16'h0000;
    mem[BASE+3] = 16'h0000; mem[BASE+4] = 16'h0000; mem[BASE+5] = 16'h0000;
    model();
    run_image(0, 1'b0);
    checks++; if (obs_timeout) begin errors++; $display("FAIL sat_timeout: no handshake within budget"); return; end
    checks++; if (logits0[0 +: W] !== 16'h7FFF) begin errors++; $display("FAIL sat_clamp: got %h expected 7fff", logits0[0 +: W]); end
    checks++; if (obs_ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf: got %b expected 1", obs_ovf); end
    repeat (4) @(negedge clk);
    checks++; if (ovf0 !== 1'b1 || done0 !== 1'b1 || logits0[0 +: W] !== 16'h7FFF) begin errors++; $display("FAIL sat_hold: ovf %b done %b logit %h expected 1 1 7fff", ovf0, done0, logits0[0 +: W]); end
    // Product clamp in both directions.
    bias_v = '{16'sh0000, 16'sh0000, 16'sh0000};
    data_v = '{16'sh7FFF, 16'sh0000};
    mem[BASE+0] = 16'h7FFF; mem[BASE+1] = 16'h8001; mem[BASE+2] = 16'h0000;
    model();
    run_image(0, 1'b0);
    checks++; if (obs_ps_ovf !== 1'b0) begin errors++; $display("FAIL sat_clear: ovf after start got %b expected 0", obs_ps_ovf); end
    checks++; if (logits0[0 +: W] !== 16'h7FFF || logits0[W +: W] !== 16'h8000) begin errors++; $display("FAIL sat_prod: got %h %h expected 7fff 8000", logits0[0 +: W], logits0[W +: W]); end
    checks++; if (obs_ovf !== exp_ovf) begin errors++; $display("FAIL sat_prod_ovf: got %b expected %b", obs_ovf, exp_ovf); end
    load_basic();
    run_image(0, 1'b0);
    checks++; if (obs_ps_ovf !== 1'b0 || obs_ovf !== 1'b0) begin errors++; $display("FAIL sat_restart_ovf: got %b/%b expected 0/0", obs_ps_ovf, obs_ovf); end
  endtask

  task automatic test_relu;
    load_basic();
    mem[BASE+2] = 16'hFF00; mem[BASE+5] = 16'h0000;
    model();
    run_image(0, 1'b0);
    checks++; if (obs_timeout) begin errors++; $display("FAIL relu_timeout: no handshake within budget"); return; end
    checks++; if (logits0[2*W +: W] !== 16'hFD00) begin errors++; $display("FAIL relu_raw: got %h expected fd00", logits0[2*W +: W]); end
    checks++; if (logits1[2*W +: W] !== 16'h0000) begin errors++; $display("FAIL relu_neg: got %h expected 0000", logits1[2*W +: W]); end
    checks++; if (logits1[0 +: W] !== 16'h0500) begin errors++; $display("FAIL relu_pos: got %h expected 0500", logits1[0 +: W]); end
    for (int n = 0; n < N; n++) begin
      checks++; if (logits1[n*W +: W] !== 16'(relu(exp_acc[n]))) begin errors++; $display("FAIL relu_model%0d: got %h expected %h", n, logits1[n*W +: W], 16'(relu(exp_acc[n]))); end
    end
  endtask

  task automatic test_reset_mid_image;
    int waited;
    load_basic();
    model();
    @(negedge clk);
    for (int n = 0; n < N; n++) biases[n*W +: W] = bias_v[n];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; data = data_v[0]; valid = 1'b1;
    waited = 0;
    while (ready0 !== 1'b1 && waited < 100) begin @(negedge clk); waited++; end
    checks++; if (waited >= 100) begin errors++; $display("FAIL mid_timeout: ready not seen within budget"); valid = 1'b0; return; end
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (logits0 !== '0 || logits1 !== '0) begin errors++; $display("FAIL mid_logits: got %h/%h expected 0", logits0, logits1); end
    checks++; if (addr0 !== AW'(BASE)) begin errors++; $display("FAIL mid_addr: got %0d expected %0d", addr0, BASE); end
    checks++; if (ready0 !== 1'b0 || done0 !== 1'b0) begin errors++; $display("FAIL mid_ctrl: ready %b done %b expected 0 0", ready0, done0); end
    @(negedge clk);
    rst_n = 1'b1;
    run_image(0, 1'b0);
    checks++; if (obs_done !== 1'b1 || obs_done_cyc != NI*(N+2)+1) begin errors++; $display("FAIL mid_rerun_done: done %b at cycle %0d expected 1 at %0d", obs_done, obs_done_cyc, NI*(N+2)+1); end
    for (int n = 0; n < N; n++) begin
      checks++; if (logits0[n*W +: W] !== basic_exp[n]) begin errors++; $display("FAIL mid_rerun_logit%0d: got %h expected %h", n, logits0[n*W +: W], basic_exp[n]); end
    end
  endtask

  task automatic test_restart_from_done;
    logic [W-1:0] rs_exp [N];
    rs_exp = '{16'h0600, 16'h0500, 16'h0180};
    checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL restart_pre_done: got %b expected 1", done0); end
    load_basic();
    bias_v = '{16'sh0200, -16'sh0100, 16'sh0080};
    model();
    run_image(0, 1'b1);
    checks++; if (obs_timeout) begin errors++; $display("FAIL restart_timeout: no handshake within budget"); return; end
    checks++; if (obs_ps_done !== 1'b0 || obs_ps_ready !== 1'b0) begin errors++; $display("FAIL restart_done_fall: done %b ready %b expected 0 0", obs_ps_done, obs_ps_ready); end
    checks++; if (obs_ps_addr !== AW'(BASE)) begin errors++; $display("FAIL restart_addr: got %0d expected %0d", obs_ps_addr, BASE); end
    checks++; if (obs_done !== 1'b1 || obs_done_cyc != NI*(N+2)+1) begin errors++; $display("FAIL restart_done: done %b at cycle %0d expected 1 at %0d", obs_done, obs_done_cyc, NI*(N+2)+1); end
    for (int n = 0; n < N; n++) begin
      checks++; if (logits0[n*W +: W] !== rs_exp[n]) begin errors++; $display("FAIL restart_logit%0d: got %h expected %h", n, logits0[n*W +: W], rs_exp[n]); end
      checks++; if (logits0[n*W +: W] !== 16'(exp_acc[n])) begin errors++; $display("FAIL restart_model%0d: got %h expected %h", n, logits0[n*W +: W], 16'(exp_acc[n])); end
    end
  endtask

  task automatic test_random;
    int gap;
    for (int it = 0; it < 30; it++) begin
      for (int n = 0; n < N; n++) bias_v[n] = rnd16();
      for (int i = 0; i < NI; i++) data_v[i] = rnd16();
      for (int k = 0; k < NI*N; k++) mem[BASE + k] = rnd16();
      gap = $urandom_range(0, 2);
      model();
      run_image(gap, 1'b0);
      checks++; if (obs_timeout) begin errors++; $display("FAIL rand%0d_timeout: no handshake within budget", it); return; end
      checks++; if (obs_done !== 1'b1 || obs_done_cyc != NI*(N+2)+1+NI*gap) begin errors++; $display("FAIL rand%0d_done: done %b at cycle %0d expected 1 at %0d", it, obs_done, obs_done_cyc, NI*(N+2)+1+NI*gap); end
      checks++; if (obs_ovf !== exp_ovf) begin errors++; $display("FAIL rand%0d_ovf: got %b expected %b", it, obs_ovf, exp_ovf); end
      checks++; if (obs_addr !== AW'(BASE + NI*N)) begin errors++; $display("FAIL rand%0d_addr: got %0d expected %0d", it, obs_addr, BASE + NI*N); end
      for (int n = 0; n < N; n++) begin
        checks++; if (logits0[n*W +: W] !== 16'(exp_acc[n])) begin errors++; $display("FAIL rand%0d_logit%0d: got %h expected %h", it, n, logits0[n*W +: W], 16'(exp_acc[n])); end
        checks++; if (logits1[n*W +: W] !== 16'(relu(exp_acc[n]))) begin errors++; $display("FAIL rand%0d_relu%0d: got %h expected %h", it, n, logits1[n*W +: W], 16'(relu(exp_acc[n]))); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < (1 << AW); a++) mem[a] = 16'($urandom);
    test_reset();
    test_basic();
    test_backpressure();
    test_saturation();
    test_relu();
    test_reset_mid_image();
    test_restart_from_done();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
